// File: rtl/isa_pkg.sv
// Shared ISA constants and the instruction word type used across the tensor-core front end.
package isa_pkg;
    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {pc, bundle} entries with push, pop, flush and occupancy count.
module fetch_queue
    import isa_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  word_t                       push_pc,
    input  logic [WIDTH*WORD_W-1:0]     push_bundle,
    output word_t                       head_pc,
    output logic [WIDTH*WORD_W-1:0]     head_bundle,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    word_t                   mem_pc     [DEPTH];
    logic [WIDTH*WORD_W-1:0] mem_bundle [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset; entries are only observable through count, which is reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[tail]     <= push_pc;
            mem_bundle[tail] <= push_bundle;
        end
    end

    assign head_pc     = empty ? '0 : mem_pc[head];
    assign head_bundle = empty ? '0 : mem_bundle[head];
endmodule

// File: rtl/fetch_wide.sv
// Multi-word fetch stage: PC/next-PC logic feeding a bundle queue read by decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_BYPASS_EN.
module fetch_wide
    import isa_pkg::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter int          FETCH_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              ihit,
    input  logic [FETCH_WIDTH*WORD_W-1:0]     imemload,
    output logic                              imemREN,
    output word_t                             imemaddr,
    input  logic                              pred_valid,
    input  word_t                             pc_prediction,
    input  logic                              misprediction,
    input  word_t                             correct_pc,
    input  logic                              freeze,
    output logic [FETCH_WIDTH*WORD_W-1:0]     instr,
    output word_t                             pc,
    output logic                              valid,
    output logic [$clog2(FETCH_DEPTH+1)-1:0]  count
);
    localparam word_t SEQ_STEP = WORD_W'(INSTR_BYTES * FETCH_WIDTH);

    word_t                         fetch_pc;
    word_t                         next_pc;
    word_t                         q_pc;
    logic [FETCH_WIDTH*WORD_W-1:0] q_bundle;
    logic                          q_empty;
    logic                          q_full;
    logic                          push_req;
    logic                          bypass;
    logic                          q_push;
    logic                          q_pop;

    assign imemREN  = !q_full && !misprediction;
    assign push_req = ihit && imemREN;
    assign imemaddr = fetch_pc;

`ifdef FETCH_BYPASS_EN
    assign bypass = push_req && q_empty && !freeze;
`else
    assign bypass = 1'b0;
`endif

    assign q_push = push_req && !bypass;
    assign q_pop  = !q_empty && !freeze && !misprediction;

    // NOTE: default first in always_comb so no path leaves next_pc unassigned (no latch).
    always_comb begin
        next_pc = fetch_pc;
        if (misprediction) begin
            next_pc = correct_pc;
        end else if (push_req) begin
            next_pc = pred_valid ? pc_prediction : fetch_pc + SEQ_STEP;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) fetch_pc <= RESET_PC;
        else       fetch_pc <= next_pc;
    end

    fetch_queue #(
        .WIDTH (FETCH_WIDTH),
        .DEPTH (FETCH_DEPTH)
    ) u_queue (
        .clk         (CLK),
        .rst_n       (nRST),
        .push        (q_push),
        .pop         (q_pop),
        .flush       (misprediction),
        .push_pc     (fetch_pc),
        .push_bundle (imemload),
        .head_pc     (q_pc),
        .head_bundle (q_bundle),
        .empty       (q_empty),
        .full        (q_full),
        .count       (count)
    );

    assign valid = bypass || !q_empty;
    assign instr = bypass ? imemload : q_bundle;
    assign pc    = bypass ? fetch_pc : q_pc;
endmodule

// File: tb/tb_fetch_wide.sv
// Scoreboard bench for fetch_wide (FETCH_WIDTH=2, FETCH_DEPTH=4, RESET_PC=0).
module tb_fetch_wide;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [63:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pred_valid;
    logic [31:0] pc_prediction;
    logic        misprediction;
    logic [31:0] correct_pc;
    logic        freeze;
    logic [63:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [95:0] sb[$];
    logic [31:0] m_pc;
    int          m_count;

    localparam logic [63:0] ACE_BUNDLE = {32'hACE1ACE1, 32'hACE2ACE2};

    fetch_wide #(
        .FETCH_WIDTH (2),
        .FETCH_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .imemload      (imemload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .pred_valid    (pred_valid),
        .pc_prediction (pc_prediction),
        .misprediction (misprediction),
        .correct_pc    (correct_pc),
        .freeze        (freeze),
        .instr         (instr),
        .pc            (pc),
        .valid         (valid),
        .count         (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bundle_of(input int k);
        return {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
    endfunction

    // Monitor: every bundle decode accepts must match the oldest expected entry.
    always @(negedge CLK) begin
        if (nRST) begin
            if (valid && !freeze && !misprediction) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle actual=%h expected=none", {pc, instr});
                end else begin
                    check("head_bundle", {pc, instr}, sb.pop_front());
                end
            end else if (!valid) begin
                check("empty_outputs", {pc, instr}, 96'h0);
            end
        end
    end

    // One cycle: called at posedge+1, drives inputs, updates the model, returns at next posedge+1.
    task automatic step(input logic ih, input logic [63:0] ld, input logic pv, input logic [31:0] pp,
                        input logic fz, input logic mp, input logic [31:0] cp);
        logic        exp_ren, push, pop, byp;
        int          n_count;
        logic [31:0] n_pc;
        ihit = ih; imemload = ld; pred_valid = pv; pc_prediction = pp;
        freeze = fz; misprediction = mp; correct_pc = cp;
        exp_ren = (m_count < 4) && !mp;
        push    = ih && exp_ren;
        pop     = (m_count > 0) && !fz && !mp;
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp     = push && (m_count == 0) && !fz;
`endif
        if (mp) begin
            sb.delete();
            n_count = 0;
            n_pc    = cp;
        end else begin
            if (push) sb.push_back({m_pc, ld});
            n_count = m_count + ((push && !byp) ? 1 : 0) - (pop ? 1 : 0);
            n_pc    = push ? (pv ? pp : m_pc + 32'd8) : m_pc;
        end
        @(negedge CLK);
        check("imemREN", 96'(imemREN), 96'(exp_ren));
        check("count", 96'(count), 96'(m_count));
        @(posedge CLK);
        #1;
        m_count = n_count;
        m_pc    = n_pc;
        check("imemaddr", 96'(imemaddr), 96'(m_pc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; imemload = '0; pred_valid = 1'b0; pc_prediction = '0;
        misprediction = 1'b0; correct_pc = '0; freeze = 1'b0;
        m_pc = 32'h0; m_count = 0;
        #12;
        check("rst_imemaddr", 96'(imemaddr), 96'h0);
        check("rst_count", 96'(count), 96'h0);
        check("rst_valid", 96'(valid), 96'h0);
        check("rst_instr_pc", {pc, instr}, 96'h0);
        check("rst_imemREN", 96'(imemREN), 96'h1);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Sequential fetch: 0 -> 8 -> 16 -> 24
        step(1'b1, ACE_BUNDLE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("seq_addr_8", 96'(imemaddr), 96'd8);
        step(1'b1, ACE_BUNDLE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("seq_addr_16", 96'(imemaddr), 96'd16);
        step(1'b1, ACE_BUNDLE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("seq_addr_24", 96'(imemaddr), 96'd24);
        idle(3);

        // Predicted target, then sequential from it
        step(1'b1, bundle_of(1), 1'b1, 32'hDEADBEE0, 1'b0, 1'b0, 32'h0);
        check("pred_target", 96'(imemaddr), 96'hDEADBEE0);
        step(1'b1, bundle_of(2), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("pred_seq", 96'(imemaddr), 96'hDEADBEE8);
        idle(3);

        // Fill under freeze, then drain in order 0, 8, 16, 24
        step(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 6; k++) step(1'b1, bundle_of(10 + k), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("full_count", 96'(count), 96'd4);
        check("full_ren", 96'(imemREN), 96'h0);
        check("full_addr_hold", 96'(imemaddr), 96'd32);
        check("full_head", {pc, instr}, {32'h0, bundle_of(10)});
        idle(5);

        // Misprediction flushes a 3-entry queue despite freeze
        for (int k = 0; k < 3; k++) step(1'b1, bundle_of(20 + k), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("pre_flush_count", 96'(count), 96'd3);
        step(1'b1, bundle_of(30), 1'b0, 32'h0, 1'b1, 1'b1, 32'hABCDEF00);
        check("flush_count", 96'(count), 96'h0);
        check("flush_valid", 96'(valid), 96'h0);
        check("flush_outputs", {pc, instr}, 96'h0);
        check("flush_addr", 96'(imemaddr), 96'hABCDEF00);

        // Address wrap past 32'hFFFFFFFF
        step(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFF8);
        step(1'b1, bundle_of(40), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", 96'(imemaddr), 96'h0);
        idle(2);

        // Asynchronous reset mid-activity
        step(1'b1, bundle_of(50), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, bundle_of(51), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst_count", 96'(count), 96'h0);
        check("async_rst_valid", 96'(valid), 96'h0);
        check("async_rst_addr", 96'(imemaddr), 96'h0);
        sb.delete();
        m_count = 0;
        m_pc    = 32'h0;
        ihit = 1'b0; freeze = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1, bundle_of(60), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(2);

        check("scoreboard_drained", 96'(sb.size()), 96'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
